// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receiver (and the planned transmitter).
// Contents:
//   PAR_NONE / PAR_ODD / PAR_EVEN  parity selector constants
//   rx_state_e                     receiver FSM state encoding
//   baud_full/baud_half/baud_cnt_w baud counter constants derived from
//                                  the clock and line rates
package rs232_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAITHI
  } rx_state_e;

  // Clocks per bit, rounded to nearest (real-to-int cast rounds).
  function automatic int baud_full(real clk_hz, real baud);
    return int'(clk_hz / baud);
  endfunction

  // Half a bit period, rounded down: first sample lands mid start bit.
  function automatic int baud_half(real clk_hz, real baud);
    return baud_full(clk_hz, baud) / 2;
  endfunction

  function automatic int baud_cnt_w(real clk_hz, real baud);
    return $clog2(baud_full(clk_hz, baud) + 1);
  endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Bit-period down-counter for the RS232 blocks.
// Ports:
//   clock, reset   system clock, async active-high reset
//   load_half_i    hold the counter at HALF (idle / waiting for start edge)
//   load_full_i    force a reload to FULL (resynchronise mid-frame)
//   tick_o         one-cycle pulse every FULL clocks; first one HALF clocks
//                  after load_half_i drops
module rs232_baud_gen #(
  parameter int FULL  = 16,
  parameter int HALF  = 8,
  parameter int CNT_W = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic load_half_i,
  input  logic load_full_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick on the last count so the reload value equals the period exactly.
  assign tick_o = !load_half_i && !load_full_i && (cnt_q == CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (load_half_i)
      cnt_d = CNT_W'(HALF);
    else if (load_full_i || tick_o)
      cnt_d = CNT_W'(FULL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= CNT_W'(HALF);
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rs232_rx_framed.sv
// RS232 receiver with framing/parity error reporting and RTS flow control.
// Ports:
//   clock, reset  system clock, async active-high reset
//   rxd_pin       serial input (idle high)
//   rtsn_pin      1 = ask the transmitter to pause; follows oafull in IDLE only
//   odata         received word, LSB first on the wire
//   oenable       one-cycle strobe qualifying odata/ferror/perror
//   ferror        a stop bit was sampled low
//   perror        parity mismatch (always 0 with PARITY = PAR_NONE)
//   oafull        downstream almost-full
// Build option: RS232_RX_FRAMED_MAJORITY_EN takes each bit as the 2-of-3
// majority of the samples at tick-1, tick, tick+1; decisions (and oenable)
// then land one cycle after the tick.
module rs232_rx_framed
  import rs232_pkg::*;
#(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0,
  parameter int  DATA_BITS  = 8,
  parameter int  PARITY     = 0,
  parameter int  STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rxd_pin,
  output logic                 rtsn_pin,
  output logic [DATA_BITS-1:0] odata,
  output logic                 oenable,
  output logic                 ferror,
  output logic                 perror,
  input  logic                 oafull
);

  localparam int FULL  = baud_full(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF  = baud_half(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = baud_cnt_w(CLOCK_FREQ, BAUD_RATE);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 stopcnt_q, stopcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d;
  logic [DATA_BITS-1:0] odata_q, odata_d;
  logic                 oen_q, oen_d, ferror_q, ferror_d, perror_q, perror_d;
  logic                 rtsn_q, rtsn_d;
  logic                 rxd, tick, samp, bit_v;

  assign rxd = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd_pin};
  end

  rs232_baud_gen #(.FULL(FULL), .HALF(HALF), .CNT_W(CNT_W)) u_baud (
    .clock       (clock),
    .reset       (reset),
    .load_half_i (state_q == IDLE),
    .load_full_i (1'b0),
    .tick_o      (tick)
  );

`ifdef RS232_RX_FRAMED_MAJORITY_EN
  // hist_q[0] = rxd one cycle ago (the tick sample), hist_q[1] = two ago.
  logic [1:0] hist_q;
  logic       tick_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q <= 2'b11;
      tick_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], rxd};
      tick_q <= tick;
    end
  end
  assign samp  = tick_q;
  assign bit_v = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd) | (hist_q[0] & rxd);
`else
  assign samp  = tick;
  assign bit_v = rxd;
`endif

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    sh_d      = sh_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    odata_d   = odata_q;
    oen_d     = 1'b0;
    ferror_d  = ferror_q;
    perror_d  = perror_q;
    rtsn_d    = rtsn_q;
    case (state_q)
      IDLE: begin
        rtsn_d = oafull;
        if (!rxd) begin
          state_d = START;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      START: if (samp) begin
        // A start bit that is high again at mid-bit was a glitch.
        if (bit_v) state_d = IDLE;
        else begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: if (samp) begin
        sh_d = {bit_v, sh_q[DATA_BITS-1:1]};
        if (bitcnt_q == 4'(DATA_BITS - 1)) begin
          state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
          stopcnt_d = 1'b0;
        end else begin
          bitcnt_d = bitcnt_q + 4'd1;
        end
      end
      PAR: if (samp) begin
        perr_d    = ((^sh_q) ^ bit_v) != (PARITY == PAR_ODD);
        state_d   = STOP;
        stopcnt_d = 1'b0;
      end
      STOP: if (samp) begin
        ferr_d = ferr_q | ~bit_v;
        if (stopcnt_q == 1'(STOP_BITS - 1)) begin
          oen_d    = 1'b1;
          odata_d  = sh_q;
          ferror_d = ferr_q | ~bit_v;
          perror_d = perr_q;
          // A low final stop bit may be a break: wait for the line to rise.
          state_d  = bit_v ? IDLE : WAITHI;
        end else begin
          stopcnt_d = 1'b1;
        end
      end
      WAITHI: if (rxd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      sh_q      <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      odata_q   <= '0;
      oen_q     <= 1'b0;
      ferror_q  <= 1'b0;
      perror_q  <= 1'b0;
      rtsn_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      sh_q      <= sh_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      odata_q   <= odata_d;
      oen_q     <= oen_d;
      ferror_q  <= ferror_d;
      perror_q  <= perror_d;
      rtsn_q    <= rtsn_d;
    end
  end

  assign odata    = odata_q;
  assign oenable  = oen_q;
  assign ferror   = ferror_q;
  assign perror   = perror_q;
  assign rtsn_pin = rtsn_q;

endmodule

// File: tb/tb_rs232_rx_framed.sv
// Bench: an 8N1 receiver (index 0) and a 7E2 receiver (index 1), both at
// 16 clocks per bit, fed from separate serial lines.
module tb_rs232_rx_framed;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] line  = 2'b11;
  logic       oafull = 1'b0;

  logic       rtsn_a, oen_a, fe_a, pe_a;
  logic [7:0] od_a;
  logic       rtsn_b, oen_b, fe_b, pe_b;
  logic [6:0] od_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int scnt [2] = '{0, 0};
  logic [8:0] sd [2];
  logic sf [2], sp [2];
  int scyc [2];
  int stop_start [2];

  always #5 clock = ~clock;

  rs232_rx_framed #(.CLOCK_FREQ(16.0e6), .BAUD_RATE(1.0e6), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clock(clock), .reset(reset), .rxd_pin(line[0]), .rtsn_pin(rtsn_a),
    .odata(od_a), .oenable(oen_a), .ferror(fe_a), .perror(pe_a), .oafull(oafull));

  rs232_rx_framed #(.CLOCK_FREQ(16.0e6), .BAUD_RATE(1.0e6), .DATA_BITS(7),
                    .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clock(clock), .reset(reset), .rxd_pin(line[1]), .rtsn_pin(rtsn_b),
    .odata(od_b), .oenable(oen_b), .ferror(fe_b), .perror(pe_b), .oafull(oafull));

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (oen_a) begin
      scnt[0] <= scnt[0] + 1; sd[0] <= {1'b0, od_a}; sf[0] <= fe_a; sp[0] <= pe_a; scyc[0] <= cyc;
    end
    if (oen_b) begin
      scnt[1] <= scnt[1] + 1; sd[1] <= {2'b00, od_b}; sf[1] <= fe_b; sp[1] <= pe_b; scyc[1] <= cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bit_out(input int d, input logic v);
    line[d] = v;
    wait_n(16);
  endtask

  // Frame on line d: 8N1 for d=0, 7E2 for d=1. flip inverts the parity bit;
  // stopv[s] is the value of stop bit s; keep_low leaves the line at the last
  // stop bit value afterwards.
  task automatic send(input int d, input logic [8:0] data, input bit flip,
                      input logic [1:0] stopv, input bit keep_low);
    int nb, nst;
    nb  = (d == 0) ? 8 : 7;
    nst = (d == 0) ? 1 : 2;
    bit_out(d, 1'b0);
    for (int i = 0; i < nb; i++) bit_out(d, data[i]);
    if (d == 1) bit_out(d, (^data[6:0]) ^ flip);
    for (int s = 0; s < nst; s++) begin
      if (s == nst - 1) stop_start[d] = cyc;
      bit_out(d, stopv[s]);
    end
    if (!keep_low) line[d] = 1'b1;
  endtask

  typedef struct {
    int         dut;
    logic [8:0] data;
    bit         flip;
    logic [1:0] stopv;
    logic [8:0] exp_d;
    bit         exp_f;
    bit         exp_p;
  } vec_t;

  vec_t vecs [9];
  int   b0, b1, lat;

  initial begin
    vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    vecs[3] = '{0, 9'h081, 1'b0, 2'b00, 9'h081, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h041, 1'b0, 2'b11, 9'h041, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h041, 1'b1, 2'b11, 9'h041, 1'b0, 1'b1};
    vecs[6] = '{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
    vecs[7] = '{1, 9'h055, 1'b0, 2'b01, 9'h055, 1'b1, 1'b0};
    vecs[8] = '{1, 9'h000, 1'b0, 2'b10, 9'h000, 1'b1, 1'b0};

    // Reset state
    wait_n(3);
    chk("rst_oenable", oen_a, 0);
    chk("rst_odata", od_a, 0);
    chk("rst_rtsn", rtsn_a, 1);
    chk("rst_ferror", fe_a, 0);
    chk("rst_perror", pe_a, 0);
    chk("rst_perror_7e2", pe_b, 0);
    reset = 1'b0;
    wait_n(4);
    chk("rtsn_idle_follow", rtsn_a, 0);

    // Short low pulse on the start bit must be rejected
    b0 = scnt[0];
    line[0] = 1'b0; wait_n(6); line[0] = 1'b1; wait_n(64);
    chk("glitch_no_strobe", scnt[0] - b0, 0);

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      b0 = scnt[0]; b1 = scnt[1];
      send(vecs[i].dut, vecs[i].data, vecs[i].flip, vecs[i].stopv, 1'b0);
      wait_n(32);
      chk($sformatf("vec%0d_strobes", i), scnt[vecs[i].dut] - ((vecs[i].dut == 0) ? b0 : b1), 1);
      chk($sformatf("vec%0d_other_quiet", i), scnt[1 - vecs[i].dut] - ((vecs[i].dut == 0) ? b1 : b0), 0);
      chk($sformatf("vec%0d_odata", i), sd[vecs[i].dut], vecs[i].exp_d);
      chk($sformatf("vec%0d_ferror", i), sf[vecs[i].dut], vecs[i].exp_f);
      chk($sformatf("vec%0d_perror", i), sp[vecs[i].dut], vecs[i].exp_p);
      // Strobe lands shortly after the last stop bit's midpoint (start+8).
      lat = scyc[vecs[i].dut] - stop_start[vecs[i].dut];
      chk($sformatf("vec%0d_latency_window lat=%0d", i, lat), (lat >= 8 && lat <= 14), 1);
    end

    // Break: bad stop bit then the line held low for 40 bit times
    b0 = scnt[0];
    send(0, 9'h03C, 1'b0, 2'b00, 1'b1);
    wait_n(40 * 16);
    chk("break_one_strobe", scnt[0] - b0, 1);
    chk("break_odata", sd[0], 9'h03C);
    chk("break_ferror", sf[0], 1);
    line[0] = 1'b1;
    wait_n(32);
    send(0, 9'h096, 1'b0, 2'b11, 1'b0);
    wait_n(32);
    chk("after_break_strobes", scnt[0] - b0, 2);
    chk("after_break_odata", sd[0], 9'h096);
    chk("after_break_ferror", sf[0], 0);

    // Flow control: rtsn only moves while idle
    b0 = scnt[0];
    chk("rtsn_pre", rtsn_a, 0);
    fork
      send(0, 9'h011, 1'b0, 2'b11, 1'b0);
      begin wait_n(40); oafull = 1'b1; wait_n(40); chk("rtsn_hold_low_midframe", rtsn_a, 0); end
    join
    wait_n(4);
    chk("rtsn_rise_after_frame", rtsn_a, 1);
    fork
      send(0, 9'h022, 1'b0, 2'b11, 1'b0);
      begin wait_n(40); oafull = 1'b0; wait_n(40); chk("rtsn_hold_high_midframe", rtsn_a, 1); end
    join
    wait_n(4);
    chk("rtsn_fall_after_frame", rtsn_a, 0);
    wait_n(16);
    chk("afull_frames_delivered", scnt[0] - b0, 2);
    chk("afull_last_odata", sd[0], 9'h022);

    // Reset in the middle of a frame
    b0 = scnt[0];
    bit_out(0, 1'b0);
    bit_out(0, 1'b1); bit_out(0, 1'b1); bit_out(0, 1'b1); bit_out(0, 1'b1);
    reset = 1'b1;
    wait_n(2);
    chk("midrst_odata", od_a, 0);
    chk("midrst_rtsn", rtsn_a, 1);
    line[0] = 1'b1;
    wait_n(2);
    reset = 1'b0;
    wait_n(48);
    chk("midrst_no_strobe", scnt[0] - b0, 0);
    send(0, 9'h05A, 1'b0, 2'b11, 1'b0);
    wait_n(32);
    chk("midrst_next_strobes", scnt[0] - b0, 1);
    chk("midrst_next_odata", sd[0], 9'h05A);
    chk("midrst_next_ferror", sf[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
